// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch requester (i_*)
// and a data requester (d_*). Ties alternate, starting with the data side.
// A busy access with no mem_ack is aborted with a fault after TIMEOUT cycles.
// Ports:
//   clk, rst_b                      clock, async active-low reset
//   i_req/i_addr                    fetch request and word address
//   i_ready/i_rdata/i_excpt         fetch completion pulse, data and fault
//   d_req/d_addr/d_wdata/d_we       data request, address, store data, byte mask
//   d_ready/d_rdata/d_excpt         data completion pulse, data and fault
//   mem_req/mem_addr/mem_wdata/mem_we  shared memory port request
//   mem_ack/mem_rdata/mem_excpt     shared memory port response
//   busy                            arbiter is not idle
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        i_req,
   input  logic [29:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   output logic        i_excpt,
   input  logic        d_req,
   input  logic [29:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_we,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_excpt,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_excpt,
   output logic        busy
);

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WE_W   = 4;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;       // 1: most recent grant went to D
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [WE_W-1:0]     we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                excpt_q, excpt_d;
   logic                mem_req_q, mem_req_d;
   logic                busy_q, busy_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;

   // Next-state, latched request and captured response.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      excpt_d = excpt_q;

      unique case (state_q)
         IDLE: begin
            // On a tie the side that did not win last time is granted.
            if (i_req && (!d_req || last_q)) begin
               addr_d  = i_addr;
               we_d    = '0;
               last_d  = 1'b0;
               state_d = I_BUSY;
            end else if (d_req) begin
               addr_d  = d_addr;
               wdata_d = d_wdata;
               we_d    = d_we;
               last_d  = 1'b1;
               state_d = D_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            // An ack on the final timeout cycle still wins over the abort.
            if (mem_ack) begin
               rdata_d = mem_rdata;
               excpt_d = mem_excpt;
               cnt_d   = '0;
               state_d = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdata_d = '0;
               excpt_d = 1'b1;
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      mem_req_d = (state_d == I_BUSY) || (state_d == D_BUSY);
      busy_d    = (state_d != IDLE);
      i_ready_d = (state_d == RESP) && !last_d;
      d_ready_d = (state_d == RESP) && last_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= '0;
         rdata_q   <= '0;
         excpt_q   <= 1'b0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         excpt_q   <= excpt_d;
         mem_req_q <= mem_req_d;
         busy_q    <= busy_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign busy      = busy_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;

   // One captured response register feeds both sides, gated by ready.
   assign i_rdata = i_ready_q ? rdata_q : '0;
   assign d_rdata = d_ready_q ? rdata_q : '0;
   assign i_excpt = i_ready_q & excpt_q;
   assign d_excpt = d_ready_q & excpt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus for mem_port_arbiter, checked every
// cycle against a transaction-level model plus hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        i_req = 1'b0;
   logic [29:0] i_addr = '0;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        i_excpt;
   logic        d_req = 1'b0;
   logic [29:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_we = '0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_excpt;
   logic        mem_req;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_excpt = 1'b0;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_b(rst_b),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_excpt(i_excpt),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_excpt(d_excpt),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_excpt(mem_excpt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: who owns the port, how long it has waited, and
   // whether this cycle is the completion cycle.
   typedef enum int {SIDE_NONE, SIDE_I, SIDE_D} side_e;
   side_e       owner = SIDE_NONE;
   side_e       last_side = SIDE_I;
   int          n_waited = 0;
   bit          in_resp = 1'b0;
   logic [31:0] m_data = '0;
   bit          m_ex = 1'b0;
   logic [29:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_we = '0;

   initial forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) begin
         owner = SIDE_NONE; last_side = SIDE_I; n_waited = 0; in_resp = 1'b0;
         m_data = '0; m_ex = 1'b0; m_addr = '0; m_wdata = '0; m_we = '0;
      end else if (in_resp) begin
         in_resp = 1'b0;
         owner   = SIDE_NONE;
      end else if (owner != SIDE_NONE) begin
         n_waited++;
         if (mem_ack) begin
            in_resp = 1'b1; m_data = mem_rdata; m_ex = mem_excpt;
         end else if (n_waited == int'(TIMEOUT)) begin
            in_resp = 1'b1; m_data = '0; m_ex = 1'b1;
         end
      end else if (i_req || d_req) begin
         if (i_req && d_req) owner = (last_side == SIDE_I) ? SIDE_D : SIDE_I;
         else if (i_req)     owner = SIDE_I;
         else                owner = SIDE_D;
         last_side = owner;
         n_waited  = 0;
         if (owner == SIDE_I) begin
            m_addr = i_addr; m_we = '0;
         end else begin
            m_addr = d_addr; m_wdata = d_wdata; m_we = d_we;
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   initial forever begin
      logic e_req, e_busy, e_ir, e_dr;
      @(negedge clk);
      e_busy = (owner != SIDE_NONE);
      e_req  = e_busy && !in_resp;
      e_ir   = in_resp && (owner == SIDE_I);
      e_dr   = in_resp && (owner == SIDE_D);
      chk("m_mem_req", 32'(mem_req), 32'(e_req));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_i_ready", 32'(i_ready), 32'(e_ir));
      chk("m_d_ready", 32'(d_ready), 32'(e_dr));
      chk("m_i_rdata", i_rdata, e_ir ? m_data : 32'h0);
      chk("m_d_rdata", d_rdata, e_dr ? m_data : 32'h0);
      chk("m_i_excpt", 32'(i_excpt), 32'(e_ir && m_ex));
      chk("m_d_excpt", 32'(d_excpt), 32'(e_dr && m_ex));
      if (e_req) begin
         chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("m_mem_we", 32'(mem_we), 32'(m_we));
         if (owner == SIDE_D) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      if (!rst_b) begin
         chk("m_rst_addr", 32'(mem_addr), 32'h0);
         chk("m_rst_wdata", mem_wdata, 32'h0);
         chk("m_rst_we", 32'(mem_we), 32'h0);
      end
   end

   initial begin
      int n_req;

      // Reset state
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_ready", 32'(d_ready), 32'h0);
      @(negedge clk);
      rst_b = 1'b1;

      // Single fetch, ack in cycle 3
      @(negedge clk);
      i_req = 1'b1; i_addr = 30'h100000;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         mem_ack   = (c == 3);
         mem_rdata = (c == 3) ? 32'h2402000a : 32'h0;
         chk("t1_mem_req", 32'(mem_req), 32'(c <= 3));
         if (c <= 3) begin
            chk("t1_mem_addr", 32'(mem_addr), 32'h100000);
            chk("t1_mem_we", 32'(mem_we), 32'h0);
         end
         chk("t1_i_ready", 32'(i_ready), 32'(c == 4));
         if (c == 4) begin
            chk("t1_i_rdata", i_rdata, 32'h2402000a);
            chk("t1_i_excpt", 32'(i_excpt), 32'h0);
            i_req = 1'b0;
         end
      end

      // Tie after reset: D, then I, then D
      @(negedge clk); #2 rst_b = 1'b0;
      @(negedge clk); #2 rst_b = 1'b1;
      @(negedge clk);
      i_req = 1'b1; i_addr = 30'h000040;
      d_req = 1'b1; d_addr = 30'h000200; d_we = 4'hf; d_wdata = 32'hdeadbeef;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1 || c == 7) begin
            chk("t2_d_mem_we", 32'(mem_we), 32'hf);
            chk("t2_d_mem_wdata", mem_wdata, 32'hdeadbeef);
            chk("t2_d_mem_addr", 32'(mem_addr), 32'h200);
         end
         if (c == 4) begin
            chk("t2_i_mem_req", 32'(mem_req), 32'h1);
            chk("t2_i_mem_we", 32'(mem_we), 32'h0);
            chk("t2_i_mem_addr", 32'(mem_addr), 32'h40);
         end
         chk("t2_d_ready", 32'(d_ready), 32'(c == 2 || c == 8));
         chk("t2_i_ready", 32'(i_ready), 32'(c == 5));
         if (c == 2) chk("t2_d_rdata", d_rdata, 32'h12345678);
         if (c == 8) begin
            i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
         end
      end

      // Timeout on a data load with no ack
      @(negedge clk);
      d_req = 1'b1; d_addr = 30'h000300; d_we = 4'h0; d_wdata = 32'h0;
      mem_rdata = 32'hffffffff;
      n_req = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (mem_req) n_req++;
         if (c == 17) begin
            chk("t3_d_ready", 32'(d_ready), 32'h1);
            chk("t3_d_excpt", 32'(d_excpt), 32'h1);
            chk("t3_d_rdata", d_rdata, 32'h0);
            d_req = 1'b0;
         end
         if (c == 18) chk("t3_busy_after", 32'(busy), 32'h0);
      end
      chk("t3_req_cycles", 32'(n_req), 32'd16);

      // Fault passthrough on a fetch
      @(negedge clk);
      i_req = 1'b1; i_addr = 30'h000500;
      @(negedge clk);
      chk("t4_mem_req", 32'(mem_req), 32'h1);
      mem_ack = 1'b1; mem_excpt = 1'b1; mem_rdata = 32'hcafef00d;
      @(negedge clk);
      chk("t4_i_ready", 32'(i_ready), 32'h1);
      chk("t4_i_excpt", 32'(i_excpt), 32'h1);
      chk("t4_i_rdata", i_rdata, 32'hcafef00d);
      chk("t4_d_ready", 32'(d_ready), 32'h0);
      i_req = 1'b0; mem_ack = 1'b0; mem_excpt = 1'b0;

      // Reset in the middle of a data access
      @(negedge clk);
      d_req = 1'b1; d_addr = 30'h000600; d_we = 4'h3; d_wdata = 32'h0badf00d;
      @(negedge clk);
      chk("t5_busy_before", 32'(busy), 32'h1);
      chk("t5_mem_req_before", 32'(mem_req), 32'h1);
      #2 rst_b = 1'b0;
      #1;
      chk("t5_mem_req_rst", 32'(mem_req), 32'h0);
      chk("t5_busy_rst", 32'(busy), 32'h0);
      chk("t5_mem_we_rst", 32'(mem_we), 32'h0);
      chk("t5_d_ready_rst", 32'(d_ready), 32'h0);
      d_req = 1'b0; i_req = 1'b1; i_addr = 30'h000700;
      @(negedge clk); #2 rst_b = 1'b1;
      @(negedge clk);
      chk("t5_i_grant", 32'(mem_req), 32'h1);
      chk("t5_i_addr", 32'(mem_addr), 32'h700);
      chk("t5_i_we", 32'(mem_we), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h00000077;
      @(negedge clk);
      chk("t5_i_ready", 32'(i_ready), 32'h1);
      chk("t5_d_ready", 32'(d_ready), 32'h0);
      i_req = 1'b0; mem_ack = 1'b0;

      // Fetch request held through its own ready cycle
      @(negedge clk);
      i_req = 1'b1; i_addr = 30'h000800; mem_ack = 1'b1; mem_rdata = 32'h00000088;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk("t6_mem_req", 32'(mem_req), 32'(c == 1 || c == 4));
         chk("t6_i_ready", 32'(i_ready), 32'(c == 2 || c == 5));
         if (c == 3) chk("t6_busy_idle", 32'(busy), 32'h0);
         if (c == 5) begin
            i_req = 1'b0; mem_ack = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
